cic_rate_controller: RTL and testbench

CIC_RATE_CONTROLLER -- requirements
Module: cic_rate_controller

---
 rtl/cic_ctrl_pkg.sv | 23 ++
 rtl/cic_settle_counter.sv | 28 ++
 rtl/cic_rate_controller.sv | 160 ++++++++++++++++
 tb/tb_cic_rate_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_ctrl_pkg.sv
// Shared state encoding and counter-width helpers for the CIC rate controller.
// Used by cic_rate_controller (optional timeout: CIC_RATE_CTRL_SETTLE_TIMEOUT_EN).
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_STOPPED = 2'd3
    } ctrl_state_t;

    localparam int DEFAULT_SETTLE_TIMEOUT = 1048576;

    // Bits needed to hold a count running 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cic_settle_counter.sv
// Saturating up-counter shared by the flush and settle phases: load clears it,
// count-enable advances it, terminal flags that it sits at the current limit.
module cic_settle_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_count_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != i_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == i_limit);

endmodule

// File: rtl/cic_rate_controller.sv
// Sequences CIC decimation-rate changes: flush the filter, discard settling
// outputs, then pass valid through. Optional macro: CIC_RATE_CTRL_SETTLE_TIMEOUT_EN.
module cic_rate_controller
    import cic_ctrl_pkg::*;
#(
    parameter int MAX_CIC_RATE   = 16384,
    parameter int RESET_RATE     = 1,
    parameter int FLUSH_CYCLES   = 4,
    parameter int SETTLE_OUTPUTS = 3,
`ifdef CIC_RATE_CTRL_SETTLE_TIMEOUT_EN
    parameter int SETTLE_TIMEOUT = DEFAULT_SETTLE_TIMEOUT,
`endif
    localparam int RATE_BITS = $clog2(MAX_CIC_RATE + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [RATE_BITS-1:0] rate_request,
    input  logic                 rate_request_valid,
    output logic                 rate_request_ready,
    output logic [RATE_BITS-1:0] cic_rate,
    output logic                 cic_reset,
    input  logic                 cic_valid_in,
    output logic                 cic_valid_out,
    output logic                 busy,
    output logic                 rate_error,
`ifdef CIC_RATE_CTRL_SETTLE_TIMEOUT_EN
    output logic                 settle_timeout,
`endif
    output ctrl_state_t          o_dbg_state
);

    localparam int                 CNT_W       = cnt_width(max2(FLUSH_CYCLES, SETTLE_OUTPUTS));
    localparam logic [CNT_W-1:0]   FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_OUTPUTS - 1);
    localparam ctrl_state_t        RESET_STATE = (RESET_RATE == 0) ? ST_STOPPED : ST_RUN;

    ctrl_state_t          r_state;
    ctrl_state_t          w_next_state;
    logic [RATE_BITS-1:0] r_cic_rate;
    logic [RATE_BITS-1:0] w_next_rate;
    logic                 r_rate_error;
    logic                 w_rate_error;
    logic                 w_accept;
    logic                 w_cnt_load;
    logic                 w_cnt_en;
    logic [CNT_W-1:0]     w_cnt_limit;
    logic                 w_cnt_done;

`ifdef CIC_RATE_CTRL_SETTLE_TIMEOUT_EN
    localparam int               TO_W    = cnt_width(SETTLE_TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(SETTLE_TIMEOUT - 1);

    logic r_settle_timeout;
    logic w_timeout_fire;
    logic w_to_done;

    cic_settle_counter #(.WIDTH(TO_W)) u_timeout_counter (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_count_en (r_state == ST_SETTLE),
        .i_limit    (TO_LAST),
        .o_terminal (w_to_done)
    );
`endif

    // One counter serves both phases; its limit follows the current state.
    assign w_cnt_en    = (r_state == ST_FLUSH) || ((r_state == ST_SETTLE) && cic_valid_in);
    assign w_cnt_limit = (r_state == ST_FLUSH) ? FLUSH_LAST : SETTLE_LAST;

    cic_settle_counter #(.WIDTH(CNT_W)) u_phase_counter (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_count_en (w_cnt_en),
        .i_limit    (w_cnt_limit),
        .o_terminal (w_cnt_done)
    );

    assign rate_request_ready = (r_state == ST_RUN) || (r_state == ST_STOPPED);
    assign w_accept           = rate_request_valid && rate_request_ready;

    always_comb begin
        w_next_state = r_state;
        w_next_rate  = r_cic_rate;
        w_rate_error = 1'b0;
        w_cnt_load   = 1'b0;
`ifdef CIC_RATE_CTRL_SETTLE_TIMEOUT_EN
        w_timeout_fire = 1'b0;
`endif
        case (r_state)
            ST_RUN, ST_STOPPED: begin
                if (w_accept) begin
                    if (rate_request > RATE_BITS'(MAX_CIC_RATE)) begin
                        w_rate_error = 1'b1;
                    end else if (rate_request != r_cic_rate) begin
                        w_next_rate  = rate_request;
                        w_next_state = ST_FLUSH;
                        w_cnt_load   = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_cnt_done) begin
                    w_cnt_load = 1'b1;
                    if (r_cic_rate == '0) begin
                        w_next_state = ST_STOPPED;
                    end else if ((r_cic_rate == RATE_BITS'(1)) || (SETTLE_OUTPUTS == 0)) begin
                        w_next_state = ST_RUN;
                    end else begin
                        w_next_state = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (cic_valid_in && w_cnt_done) begin
                    w_next_state = ST_RUN;
`ifdef CIC_RATE_CTRL_SETTLE_TIMEOUT_EN
                end else if (w_to_done) begin
                    w_next_state   = ST_RUN;
                    w_timeout_fire = 1'b1;
`endif
                end
            end
            default: w_next_state = RESET_STATE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= RESET_STATE;
            r_cic_rate   <= RATE_BITS'(RESET_RATE);
            r_rate_error <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cic_rate   <= w_next_rate;
            r_rate_error <= w_rate_error;
        end
    end

`ifdef CIC_RATE_CTRL_SETTLE_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_settle_timeout <= 1'b0;
        end else begin
            r_settle_timeout <= w_timeout_fire;
        end
    end

    assign settle_timeout = r_settle_timeout;
`endif

    assign cic_rate      = r_cic_rate;
    assign cic_reset     = (r_state == ST_FLUSH);
    assign cic_valid_out = (r_state == ST_RUN) && cic_valid_in;
    assign busy          = (r_state != ST_RUN);
    assign rate_error    = r_rate_error;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_cic_rate_controller.sv
// Self-checking bench for cic_rate_controller; define CIC_RATE_CTRL_SETTLE_TIMEOUT_EN
// to also exercise the settle timeout with SETTLE_TIMEOUT = 100.
module tb_cic_rate_controller;
    import cic_ctrl_pkg::*;

    localparam int RB = $clog2(16384 + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [RB-1:0] rate_request = '0;
    logic          rate_request_valid = 1'b0;
    logic          rate_request_ready;
    logic [RB-1:0] cic_rate;
    logic          cic_reset;
    logic          cic_valid_in = 1'b0;
    logic          cic_valid_out;
    logic          busy;
    logic          rate_error;
    ctrl_state_t   dbg_state;
`ifdef CIC_RATE_CTRL_SETTLE_TIMEOUT_EN
    logic          settle_timeout;
`endif

    int checks   = 0;
    int failures = 0;
    logic [0:0] exp_q[$];

    // ---------------- clock / reset / DUT ----------------
    always #5 clock = ~clock;

    cic_rate_controller #(
        .MAX_CIC_RATE   (16384),
        .RESET_RATE     (1),
        .FLUSH_CYCLES   (4),
`ifdef CIC_RATE_CTRL_SETTLE_TIMEOUT_EN
        .SETTLE_TIMEOUT (100),
`endif
        .SETTLE_OUTPUTS (3)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .rate_request       (rate_request),
        .rate_request_valid (rate_request_valid),
        .rate_request_ready (rate_request_ready),
        .cic_rate           (cic_rate),
        .cic_reset          (cic_reset),
        .cic_valid_in       (cic_valid_in),
        .cic_valid_out      (cic_valid_out),
        .busy               (busy),
        .rate_error         (rate_error),
`ifdef CIC_RATE_CTRL_SETTLE_TIMEOUT_EN
        .settle_timeout     (settle_timeout),
`endif
        .o_dbg_state        (dbg_state)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one request for one cycle; returns just after the accepting edge.
    task automatic send_req(input logic [RB-1:0] r);
        rate_request       = r;
        rate_request_valid = 1'b1;
        tick();
        rate_request_valid = 1'b0;
    endtask

    // Counts consecutive cycles with cic_reset high; returns in the first cycle after.
    task automatic measure_flush(output int n);
        n = 0;
        while (cic_reset && n < 50) begin
            n++;
            tick();
        end
    endtask

    // One cic_valid_in pulse; expected pass-through goes on the scoreboard queue.
    task automatic pulse_in(input logic exp_pass);
        logic [0:0] got;
        logic [0:0] exp_v;
        exp_q.push_back(exp_pass);
        cic_valid_in = 1'b1;
        @(negedge clock);
        got = cic_valid_out;
        @(posedge clock);
        #1;
        cic_valid_in = 1'b0;
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL valid_out_scoreboard got=%0d exp=%0d t=%0t", got, exp_v, $time);
        end
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (dbg_state !== ST_RUN) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_RUN); end
        checks++; if (cic_rate !== RB'(1)) begin failures++; $display("FAIL reset_rate got=%0d exp=1", cic_rate); end
        checks++; if (rate_request_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", rate_request_ready); end
        checks++; if (busy !== 1'b0 || cic_reset !== 1'b0 || rate_error !== 1'b0 || cic_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%0b cic_reset=%0b err=%0b vout=%0b exp all 0", busy, cic_reset, rate_error, cic_valid_out);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        send_req(RB'(20000));
        checks++; if (rate_error !== 1'b1) begin failures++; $display("FAIL illegal_error_pulse got=%0b exp=1", rate_error); end
        checks++; if (cic_rate !== RB'(1)) begin failures++; $display("FAIL illegal_rate_kept got=%0d exp=1", cic_rate); end
        checks++; if (cic_reset !== 1'b0 || dbg_state !== ST_RUN) begin
            failures++;
            $display("FAIL illegal_no_flush got cic_reset=%0b state=%0d exp 0/%0d", cic_reset, dbg_state, ST_RUN);
        end
        tick();
        checks++; if (rate_error !== 1'b0) begin failures++; $display("FAIL illegal_error_one_cycle got=%0b exp=0", rate_error); end
    endtask

    task automatic test_same_rate();
        send_req(RB'(1));
        checks++; if (cic_reset !== 1'b0 || rate_request_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL same_rate_noop got cic_reset=%0b ready=%0b busy=%0b exp 0/1/0", cic_reset, rate_request_ready, busy);
        end
        tick();
        checks++; if (cic_reset !== 1'b0) begin failures++; $display("FAIL same_rate_no_late_flush got=%0b exp=0", cic_reset); end
    endtask

    task automatic test_flush_settle();
        int n;
        send_req(RB'(64));
        checks++; if (rate_request_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_ready_busy got ready=%0b busy=%0b exp 0/1", rate_request_ready, busy);
        end
        checks++; if (cic_rate !== RB'(64)) begin failures++; $display("FAIL flush_rate got=%0d exp=64", cic_rate); end
        measure_flush(n);
        checks++; if (n !== 4) begin failures++; $display("FAIL flush_len got=%0d exp=4", n); end
        checks++; if (dbg_state !== ST_SETTLE) begin failures++; $display("FAIL settle_entry got=%0d exp=%0d", dbg_state, ST_SETTLE); end
        repeat (3) pulse_in(1'b0);
        checks++; if (busy !== 1'b0 || dbg_state !== ST_RUN) begin
            failures++;
            $display("FAIL settle_done got busy=%0b state=%0d exp 0/%0d", busy, dbg_state, ST_RUN);
        end
        pulse_in(1'b1);
    endtask

    task automatic test_bypass();
        int n;
        send_req(RB'(1));
        measure_flush(n);
        checks++; if (n !== 4) begin failures++; $display("FAIL bypass_flush_len got=%0d exp=4", n); end
        checks++; if (dbg_state !== ST_RUN || busy !== 1'b0) begin
            failures++;
            $display("FAIL bypass_run got state=%0d busy=%0b exp %0d/0", dbg_state, busy, ST_RUN);
        end
        pulse_in(1'b1);
    endtask

    task automatic test_stop();
        int n;
        send_req(RB'(0));
        measure_flush(n);
        checks++; if (n !== 4) begin failures++; $display("FAIL stop_flush_len got=%0d exp=4", n); end
        checks++; if (dbg_state !== ST_STOPPED || rate_request_ready !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL stopped got state=%0d ready=%0b busy=%0b exp %0d/1/1", dbg_state, rate_request_ready, busy, ST_STOPPED);
        end
        repeat (4) pulse_in(1'b0);
        send_req(RB'(8));
        checks++; if (cic_rate !== RB'(8)) begin failures++; $display("FAIL restart_rate got=%0d exp=8", cic_rate); end
        measure_flush(n);
        checks++; if (n !== 4) begin failures++; $display("FAIL restart_flush_len got=%0d exp=4", n); end
        repeat (3) pulse_in(1'b0);
        pulse_in(1'b1);
    endtask

    // Requester holds valid high through FLUSH/SETTLE; the held request must land afterwards.
    task automatic test_back_to_back();
        int n;
        rate_request       = RB'(2);
        rate_request_valid = 1'b1;
        tick();
        rate_request = RB'(5);
        checks++; if (rate_request_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_low got=%0b exp=0", rate_request_ready); end
        measure_flush(n);
        checks++; if (n !== 4 || cic_rate !== RB'(2)) begin
            failures++;
            $display("FAIL b2b_first got flush=%0d rate=%0d exp 4/2", n, cic_rate);
        end
        repeat (3) pulse_in(1'b0);
        rate_request_valid = 1'b0;
        checks++; if (cic_rate !== RB'(5) || cic_reset !== 1'b1) begin
            failures++;
            $display("FAIL b2b_held_accepted got rate=%0d cic_reset=%0b exp 5/1", cic_rate, cic_reset);
        end
        measure_flush(n);
        checks++; if (n !== 4) begin failures++; $display("FAIL b2b_second_flush got=%0d exp=4", n); end
        repeat (3) pulse_in(1'b0);
        pulse_in(1'b1);
    endtask

    task automatic test_reset_mid_settle();
        int n;
        send_req(RB'(64));
        measure_flush(n);
        pulse_in(1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (dbg_state !== ST_RUN || cic_rate !== RB'(1) || busy !== 1'b0 || cic_reset !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_settle got state=%0d rate=%0d busy=%0b cic_reset=%0b exp %0d/1/0/0", dbg_state, cic_rate, busy, cic_reset, ST_RUN);
        end
        tick();
        reset = 1'b0;
        tick();
        send_req(RB'(64));
        measure_flush(n);
        checks++; if (n !== 4) begin failures++; $display("FAIL post_reset_flush got=%0d exp=4", n); end
        repeat (3) pulse_in(1'b0);
        pulse_in(1'b1);
    endtask

`ifdef CIC_RATE_CTRL_SETTLE_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int k;
        send_req(RB'(16));
        measure_flush(n);
        k = 0;
        while (settle_timeout !== 1'b1 && k < 300) begin
            k++;
            tick();
        end
        checks++; if (k !== 100) begin failures++; $display("FAIL timeout_cycles got=%0d exp=100", k); end
        checks++; if (dbg_state !== ST_RUN) begin failures++; $display("FAIL timeout_run got=%0d exp=%0d", dbg_state, ST_RUN); end
        tick();
        checks++; if (settle_timeout !== 1'b0) begin failures++; $display("FAIL timeout_pulse_width got=%0b exp=0", settle_timeout); end
    endtask
`endif

    initial begin
        test_reset();
        test_illegal();
        test_same_rate();
        test_flush_settle();
        test_bypass();
        test_stop();
        test_back_to_back();
        test_reset_mid_settle();
`ifdef CIC_RATE_CTRL_SETTLE_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
